// File: rtl/branch_history_sched.sv
// -----------------------------------------------------------------------------
// branch_history_sched
//
// Write-port scheduler for the branch history table (2^INDEX_W entries of
// HIST_W bits) of the pipelined LC-3b core. It is the only master of the
// table's write port.
//
//   * Resolved-branch outcomes arrive from MEM over a ready/valid handshake
//     and are buffered in a DEPTH-entry FIFO.
//   * In RUN, one outcome per cycle is drained as a read-modify-write shift
//     of the addressed history entry. The registered write of the previous
//     cycle is forwarded when it targets the same entry, because the table
//     has not absorbed it yet.
//   * In CLEAR (after reset, or on clear_req) the table is zeroed with a
//     one-entry-per-cycle sweep. The FIFO keeps accepting during the sweep.
//
// Optional feature (macro BHT_SCHED_BYPASS_EN):
//   When defined, a resolution accepted in RUN while the FIFO is empty and
//   no clear is requested is processed in its accept cycle instead of being
//   enqueued, giving 1-cycle write latency instead of 2.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   res_valid       resolved branch presented
//   res_index       table entry of the resolved branch
//   res_taken       branch outcome (1 = taken)
//   res_ready       FIFO can accept this cycle (0 while in reset)
//   clear_req       single-cycle request to zero the whole table
//   clear_busy      zeroing sweep in progress
//   tbl_rd_index    combinational read address to the table
//   tbl_rd_data     combinational read data from the table
//   wr_en           registered table write strobe
//   wr_index        registered table write address
//   wr_data         registered table write data
// -----------------------------------------------------------------------------
module branch_history_sched #(
  parameter int DEPTH   = 4,
  parameter int INDEX_W = 5,
  parameter int HIST_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               res_valid,
  input  logic [INDEX_W-1:0] res_index,
  input  logic               res_taken,
  output logic               res_ready,
  input  logic               clear_req,
  output logic               clear_busy,
  output logic [INDEX_W-1:0] tbl_rd_index,
  input  logic [HIST_W-1:0]  tbl_rd_data,
  output logic               wr_en,
  output logic [INDEX_W-1:0] wr_index,
  output logic [HIST_W-1:0]  wr_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [INDEX_W-1:0] LAST_INDEX = '1;
  localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [INDEX_W-1:0] sweep_cnt, sweep_next;

  // FIFO storage and bookkeeping
  logic [INDEX_W-1:0] fifo_index [DEPTH];
  logic               fifo_taken [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               full, empty;
  logic               push, pop, flush, bypass;
  logic               upd_valid, upd_taken;
  logic [INDEX_W-1:0] upd_index;
  logic [HIST_W-1:0]  src_hist, new_hist;

  // ---------------------------------------------------------------------------
  // Handshake and FIFO control
  // ---------------------------------------------------------------------------
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Ready is gated by reset so MEM cannot hand over a result while the
  // scheduler is being reset.
  assign res_ready = rst_n & ~full;

  // A clear request in RUN discards everything queued at this edge and wins
  // over the pop; the head of this cycle is dropped, not written.
  assign flush = (state == ST_RUN) & clear_req;
  assign pop   = (state == ST_RUN) & ~clear_req & ~empty;

`ifdef BHT_SCHED_BYPASS_EN
  assign bypass = (state == ST_RUN) & ~clear_req & empty & res_valid & res_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push = res_valid & res_ready & ~bypass;

  // ---------------------------------------------------------------------------
  // Read-modify-write of the addressed history entry
  // ---------------------------------------------------------------------------
  assign upd_valid = pop | bypass;
  assign upd_index = pop ? fifo_index[rd_ptr] : res_index;
  assign upd_taken = pop ? fifo_taken[rd_ptr] : res_taken;

  assign tbl_rd_index = upd_valid ? upd_index : '0;

  // The write registered last cycle lands in the table only at the coming
  // edge, so a back-to-back update of the same entry must take it from here.
  assign src_hist = (wr_en && (wr_index == upd_index)) ? wr_data : tbl_rd_data;
  assign new_hist = {src_hist[HIST_W-2:0], upd_taken};

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    sweep_next = sweep_cnt;
    unique case (state)
      ST_CLEAR: begin
        if (clear_req) begin
          sweep_next = '0;
        end else if (sweep_cnt == LAST_INDEX) begin
          sweep_next = '0;
          state_next = ST_RUN;
        end else begin
          sweep_next = sweep_cnt + INDEX_W'(1);
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
          sweep_next = '0;
        end
      end
      default: begin
        state_next = ST_CLEAR;
        sweep_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      sweep_cnt <= '0;
    end else begin
      state     <= state_next;
      sweep_cnt <= sweep_next;
    end
  end

  assign clear_busy = (state == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Registered table write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_index <= '0;
      wr_data  <= '0;
    end else if (state == ST_CLEAR) begin
      wr_en    <= 1'b1;
      wr_index <= sweep_cnt;
      wr_data  <= '0;
    end else if (upd_valid) begin
      wr_en    <= 1'b1;
      wr_index <= upd_index;
      wr_data  <= new_hist;
    end else begin
      wr_en    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // A result accepted in the clearing cycle survives as the sole entry.
      rd_ptr <= wr_ptr;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        count  <= CNT_W'(1);
      end else begin
        count  <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // NOTE: the payload array has no reset; occupancy and pointers decide
  // which slots are meaningful, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_index[wr_ptr] <= res_index;
      fifo_taken[wr_ptr] <= res_taken;
    end
  end

endmodule
